axi_burst_ram_responder: RTL and testbench

//  AXI4 slave burst RAM: the responder for the MM2S read DMA and S2MM write DMA masters.

---
 rtl/axi_burst_ram_responder_if.sv | 57 +++++
 rtl/axi_burst_ram_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi_burst_ram_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_ram_responder_if.sv
// AXI4 slave-side bus bundle for the burst RAM responder: AW/W/B/AR/R channels.
// The master modport is the DMA side, the slave modport is the RAM side.
interface axi_burst_ram_responder_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_ram_responder.sv
// AXI4 INCR burst RAM slave with independent read and write FSMs, one beat per cycle each.
// Optional macro AXI_RAM_DECERR_EN: out-of-range bursts answer DECERR instead of aliasing.
module axi_burst_ram_responder #(
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 6,
    parameter int                    MEM_AW     = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    axi_burst_ram_responder_if.slave s_axi,
    output logic [1:0]            dbg_w_state,
    output logic [1:0]            dbg_r_state
);
    // Every channel transfers on a clock edge where valid && ready are both high;
    // valid never waits for ready, and payload is held stable while valid && !ready.

    localparam int         STRB_W    = DATA_WIDTH / 8;
    localparam int         BYTE_LOG  = $clog2(STRB_W);
    localparam int         DEPTH     = 1 << MEM_AW;
    localparam logic [2:0] SIZE_FULL = 3'(BYTE_LOG);
    localparam logic [1:0] BURST_INC = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;
    localparam logic [1:0] RESP_DEC  = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} r_state_e;

    function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> BYTE_LOG);
    endfunction

    logic aw_oor;
    logic ar_oor;
`ifdef AXI_RAM_DECERR_EN
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> (BYTE_LOG + MEM_AW)) != '0);
    endfunction
    assign aw_oor = out_of_range(s_axi.awaddr);
    assign ar_oor = out_of_range(s_axi.araddr);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata_q;
    logic                  mem_we;
    logic                  ram_re;

    // ---------------- write channel ----------------
    w_state_e            w_state_q, w_state_d;
    logic                awready_q, awready_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [MEM_AW-1:0]   w_idx_q, w_idx_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [7:0]          w_cnt_q, w_cnt_d;
    logic                w_slverr_q, w_slverr_d;
    logic                w_decerr_q, w_decerr_d;
    logic                w_lasterr_q, w_lasterr_d;
    logic [1:0]          w_resp;

    always_comb begin
        w_state_d   = w_state_q;
        w_id_d      = w_id_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_slverr_d  = w_slverr_q;
        w_decerr_d  = w_decerr_q;
        w_lasterr_d = w_lasterr_q;
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    w_id_d      = s_axi.awid;
                    w_idx_d     = word_index(s_axi.awaddr);
                    w_len_d     = s_axi.awlen;
                    w_cnt_d     = 8'd0;
                    w_slverr_d  = (s_axi.awburst != BURST_INC) || (s_axi.awsize != SIZE_FULL);
                    w_decerr_d  = aw_oor;
                    w_lasterr_d = 1'b0;
                    w_state_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.wvalid) begin
                    mem_we  = !w_decerr_q;
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q + 1'b1;
                    // The burst length comes from awlen; a misplaced wlast only taints the response.
                    if (s_axi.wlast != (w_cnt_q == w_len_q)) begin
                        w_lasterr_d = 1'b1;
                    end
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            w_id_q      <= '0;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            w_slverr_q  <= 1'b0;
            w_decerr_q  <= 1'b0;
            w_lasterr_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            w_id_q      <= w_id_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            w_slverr_q  <= w_slverr_d;
            w_decerr_q  <= w_decerr_d;
            w_lasterr_q <= w_lasterr_d;
        end
    end

    assign w_resp = w_decerr_q ? RESP_DEC :
                    (w_slverr_q || w_lasterr_q) ? RESP_SLV : RESP_OKAY;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bid     = w_id_q;
    assign s_axi.bresp   = (w_state_q == W_RESP) ? w_resp : RESP_OKAY;
    assign dbg_w_state   = w_state_q;

    // ---------------- read channel ----------------
    // Two stages stall together: the RAM read register and the R output register.
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_done_q, r_done_d;
    logic                  r_slverr_q, r_slverr_d;
    logic                  r_decerr_q, r_decerr_d;
    logic                  pend_q, pend_d;
    logic                  pend_last_q, pend_last_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  r_adv;

    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_done_d    = r_done_q;
        r_slverr_d  = r_slverr_q;
        r_decerr_d  = r_decerr_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rid_d       = rid_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        ram_re      = 1'b0;
        r_adv       = !rvalid_q || s_axi.rready;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    r_id_d     = s_axi.arid;
                    r_idx_d    = word_index(s_axi.araddr);
                    r_len_d    = s_axi.arlen;
                    r_cnt_d    = 8'd0;
                    r_done_d   = 1'b0;
                    r_slverr_d = (s_axi.arburst != BURST_INC) || (s_axi.arsize != SIZE_FULL);
                    r_decerr_d = ar_oor;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_adv && !r_done_q) begin
                    ram_re   = 1'b1;
                    r_idx_d  = r_idx_q + 1'b1;
                    r_cnt_d  = r_cnt_q + 1'b1;
                    r_done_d = (r_cnt_q == r_len_q);
                end
                if (rvalid_q && s_axi.rready && rlast_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_adv) begin
            pend_d      = ram_re;
            pend_last_d = ram_re && (r_cnt_q == r_len_q);
            rvalid_d    = pend_q;
            if (pend_q) begin
                rdata_d = r_decerr_q ? '0 : ram_rdata_q;
                rid_d   = r_id_q;
                rresp_d = r_decerr_q ? RESP_DEC : (r_slverr_q ? RESP_SLV : RESP_OKAY);
                rlast_d = pend_last_q;
            end
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            r_id_q      <= '0;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_cnt_q     <= '0;
            r_done_q    <= 1'b0;
            r_slverr_q  <= 1'b0;
            r_decerr_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rid_q       <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            r_id_q      <= r_id_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_cnt_q     <= r_cnt_d;
            r_done_q    <= r_done_d;
            r_slverr_q  <= r_slverr_d;
            r_decerr_q  <= r_decerr_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rid_q       <= rid_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    assign dbg_r_state   = r_state_q;

    // Non-blocking read and write on one edge: a same-word read sees the old contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[r_idx_q];
        end
    end
endmodule

// File: tb/tb_axi_burst_ram_responder.sv
// Self-checking bench for axi_burst_ram_responder: table-driven write/read bursts plus
// hand-written corner sequences, checked through B/R expectation queues and a RAM model.
module tb_axi_burst_ram_responder;
    localparam int DW     = 128;
    localparam int AW     = 32;
    localparam int IDW    = 6;
    localparam int MEM_AW = 12;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int RW     = IDW + 2 + 1 + DW;
    localparam int BW     = IDW + 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_burst_ram_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) axi ();
    logic [1:0] dbg_w_state;
    logic [1:0] dbg_r_state;

    axi_burst_ram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .MEM_AW(MEM_AW), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rstn(rstn), .s_axi(axi.slave),
        .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
    );

    typedef struct {
        logic [IDW-1:0] id;   logic [31:0] addr; logic [7:0] len; logic [1:0] burst;
        logic [2:0] size;     int wlast_beat;    logic [15:0] strb; logic [DW-1:0] seed;
        logic [1:0] exp_resp;
    } wvec_t;
    typedef struct {
        logic [IDW-1:0] id;   logic [31:0] addr; logic [7:0] len; logic [1:0] burst;
        logic [2:0] size;     int mode;          logic [1:0] exp_resp;
    } rvec_t;

    int errors = 0;
    int checks = 0;
    int r_beat_cnt = 0;
    logic [DW-1:0] model [DEPTH];
    logic [RW-1:0] exp_q[$];
    logic [BW-1:0] exp_b_q[$];
    logic [RW-1:0] cur_r, held_r, exp_r;
    logic [BW-1:0] exp_b;
    logic hold_pend = 1'b0;
    wvec_t wv[6];
    rvec_t rv[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic oor(input logic [31:0] a);
`ifdef AXI_RAM_DECERR_EN
        return a >= 32'h0001_0000;
`else
        return a[0] & 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[15:4]);
    endfunction

    // Output monitor: sampled on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_pend = 1'b0;
        end else begin
            if (axi.bvalid && axi.bready) begin
                if (exp_b_q.size() == 0) chk("b_unexpected", {axi.bid, axi.bresp}, '1);
                else begin
                    exp_b = exp_b_q.pop_front();
                    chk("b_id_resp", {axi.bid, axi.bresp}, exp_b);
                end
            end
            cur_r = {axi.rid, axi.rresp, axi.rlast, axi.rdata};
            if (hold_pend) chk("r_stall_hold", {axi.rvalid, cur_r}, {1'b1, held_r});
            if (axi.rvalid && axi.rready) begin
                if (exp_q.size() == 0) chk("r_unexpected", cur_r, '1);
                else begin
                    exp_r = exp_q.pop_front();
                    chk("r_beat", cur_r, exp_r);
                end
                r_beat_cnt++;
            end
            hold_pend = axi.rvalid && !axi.rready;
            held_r    = cur_r;
        end
    end

    task automatic do_write(input wvec_t v);
        int n;
        int base;
        logic [DW-1:0] d;
        exp_b_q.push_back({v.id, v.exp_resp});
        base = widx(v.addr);
        axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
        axi.awsize = v.size; axi.awburst = v.burst; axi.awvalid = 1'b1;
        axi.wdata = v.seed; axi.wstrb = v.strb; axi.wlast = (v.wlast_beat == 0);
        axi.wvalid = 1'b1; axi.bready = 1'b0;
        @(negedge clk);
        chk("w_before_aw", axi.wready, 1'b0);
        n = 0;
        while (!axi.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", axi.awready, 1'b1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            d = v.seed + DW'(i);
            axi.wdata = d; axi.wstrb = v.strb; axi.wlast = (i == v.wlast_beat); axi.wvalid = 1'b1;
            @(negedge clk);
            n = 0;
            while (!axi.wready && n < 50) begin @(negedge clk); n++; end
            if (!axi.wready) begin chk("w_ready", axi.wready, 1'b1); break; end
            if (!oor(v.addr)) begin
                for (int b = 0; b < DW/8; b++)
                    if (v.strb[b]) model[(base + i) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
            end
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        chk("b_valid_next", axi.bvalid, 1'b1);
        n = 0;
        while (exp_b_q.size() != 0 && n < 50) begin
            axi.bready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (exp_b_q.size() != 0) begin chk("b_timeout", exp_b_q.size(), 0); exp_b_q.delete(); end
        axi.bready = 1'b0;
    endtask

    task automatic push_read(input rvec_t v);
        logic [DW-1:0] d;
        for (int i = 0; i <= int'(v.len); i++) begin
            d = oor(v.addr) ? '0 : model[(widx(v.addr) + i) % DEPTH];
            exp_q.push_back({v.id, v.exp_resp, (i == int'(v.len)), d});
        end
    endtask

    task automatic send_ar(input rvec_t v);
        int n;
        axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len;
        axi.arsize = v.size; axi.arburst = v.burst; axi.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", axi.arready, 1'b1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic do_read(input rvec_t v);
        int n;
        push_read(v);
        axi.rready = 1'b1;
        send_ar(v);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            case (v.mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = n[0];
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin chk("r_timeout", exp_q.size(), 0); exp_q.delete(); end
        axi.rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t w;
        rvec_t r;
        int n;
        wv[0] = '{6'd5,  32'h0000, 8'd3, 2'b01, 3'd4, 3, 16'hFFFF, 128'd1, 2'b00};
        wv[1] = '{6'd1,  32'h0100, 8'd0, 2'b00, 3'd4, 0, 16'hFFFF, {4{$urandom}}, 2'b10};
        wv[2] = '{6'd2,  32'h0200, 8'd1, 2'b01, 3'd2, 1, 16'hFFFF, {4{$urandom}}, 2'b10};
        wv[3] = '{6'd3,  32'h0300, 8'd3, 2'b01, 3'd4, 2, 16'hFFFF, {4{$urandom}}, 2'b10};
        wv[4] = '{6'd4,  32'h0400, 8'd1, 2'b01, 3'd4, 1, 16'hFFFF, {4{$urandom}}, 2'b00};
        wv[5] = '{6'd63, 32'hFFF0, 8'd0, 2'b01, 3'd4, 0, 16'hFFFF, {4{$urandom}}, 2'b00};
        rv[0] = '{6'd9,  32'h0000, 8'd3, 2'b01, 3'd4, 0, 2'b00};
        rv[1] = '{6'd1,  32'h0300, 8'd3, 2'b01, 3'd4, 1, 2'b00};
        rv[2] = '{6'd2,  32'h0100, 8'd0, 2'b10, 3'd4, 0, 2'b10};
        rv[3] = '{6'd3,  32'h0400, 8'd1, 2'b01, 3'd3, 2, 2'b10};
        rv[4] = '{6'd4,  32'hFFF0, 8'd1, 2'b01, 3'd4, 2, 2'b00};
        rv[5] = '{6'd10, 32'h0200, 8'd1, 2'b01, 3'd4, 2, 2'b00};

        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

        // Reset state
        #22;
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_arready", axi.arready, 1'b0);
        chk("rst_wready", axi.wready, 1'b0);
        chk("rst_bvalid_bresp_bid", {axi.bvalid, axi.bresp, axi.bid}, '0);
        chk("rst_r_outputs", {axi.rvalid, axi.rresp, axi.rlast, axi.rid, axi.rdata}, '0);
        chk("rst_fsm_states", {dbg_w_state, dbg_r_state}, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", axi.awready, 1'b1);
        chk("rel_arready", axi.arready, 1'b1);

        // Fill words 0..15 so every later read sees known contents
        w = '{6'd0, 32'h0, 8'd15, 2'b01, 3'd4, 15, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 2'b00};
        do_write(w);

        for (int i = 0; i < 6; i++) do_write(wv[i]);
        for (int i = 0; i < 6; i++) do_read(rv[i]);

        // Partial strobe merge into word 0
        w = '{6'd7, 32'h0, 8'd0, 2'b01, 3'd4, 0, 16'hFFFF, '1, 2'b00};
        do_write(w);
        w = '{6'd8, 32'h0, 8'd0, 2'b01, 3'd4, 0, 16'h000F, 128'hAABBCCDD, 2'b00};
        do_write(w);
        chk("t2_model_merge", model[0], {{96{1'b1}}, 32'hAABBCCDD});
        r = '{6'd11, 32'h0, 8'd0, 2'b01, 3'd4, 0, 2'b00};
        do_read(r);

        // 8-beat read with rready toggling
        r = '{6'd12, 32'h0, 8'd7, 2'b01, 3'd4, 1, 2'b00};
        do_read(r);

        // Start address one past the RAM span
`ifdef AXI_RAM_DECERR_EN
        w = '{6'd13, 32'h0001_0000, 8'd0, 2'b01, 3'd4, 0, 16'hFFFF, {4{$urandom}}, 2'b11};
        do_write(w);
        r = '{6'd14, 32'h0001_0000, 8'd1, 2'b01, 3'd4, 0, 2'b11};
`else
        w = '{6'd13, 32'h0001_0000, 8'd0, 2'b01, 3'd4, 0, 16'hFFFF, {4{$urandom}}, 2'b00};
        do_write(w);
        r = '{6'd14, 32'h0001_0000, 8'd1, 2'b01, 3'd4, 0, 2'b00};
`endif
        do_read(r);
        r = '{6'd15, 32'h0, 8'd1, 2'b01, 3'd4, 0, 2'b00};
        do_read(r);

        // Reset while the second beat of a read is on the bus
        r = '{6'd16, 32'h0300, 8'd7, 2'b01, 3'd4, 0, 2'b00};
        r_beat_cnt = 0;
        push_read(r);
        axi.rready = 1'b1;
        send_ar(r);
        n = 0;
        while (r_beat_cnt < 1 && n < 50) begin @(posedge clk); #3; n++; end
        chk("t5_beat2_valid", axi.rvalid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t5_rvalid_cleared", axi.rvalid, 1'b0);
        chk("t5_arready_cleared", axi.arready, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("t5_arready_after", axi.arready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_stale_beats", {axi.rvalid, axi.bvalid}, 2'b00);
        r = '{6'd17, 32'h0300, 8'd1, 2'b01, 3'd4, 0, 2'b00};
        do_read(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
